// File: rtl/text_overlay.sv
// text_overlay: scaled bitmap-text overlay stage for the VGA pixel chain, 2-clk latency.
// Define TEXT_OVERLAY_TRANSPARENT_EN to show rgb_in instead of BG behind the glyphs.
module text_overlay #(
  parameter int N_CHARS = 8,
  parameter int CHARS_PER_ROW = 4,
  parameter int SCALE = 9,
  parameter int X0 = 120,
  parameter int Y0 = 135,
  parameter int CHAR_PITCH = 100,
  parameter int ROW_PITCH = 120,
  parameter int BLINK_FRAMES = 0,
  parameter logic [23:0] FG = 24'hFFFFFF,
  parameter logic [23:0] BG = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [2:0]  wr_code,
  input  logic [9:0]  hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blnk_in,
  input  logic [23:0] rgb_in,
  output logic [9:0]  hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blnk_out,
  output logic [23:0] rgb_out
);
  localparam int IW = N_CHARS > 1 ? $clog2(N_CHARS) : 1;
  localparam int CW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  // Each glyph is {row0..row9}; row 0 is the top, bit 10 of a row is the leftmost column.
  localparam logic [109:0] FONT [8] = '{
    110'd0,
    {11'b00011111100, 11'b00110000110, 11'b01100000000, 11'b01100000000, 11'b01100011110,
     11'b01100000110, 11'b01100000110, 11'b00110000110, 11'b00011111100, 11'b00000000000},
    {11'b00001110000, 11'b00011011000, 11'b00110001100, 11'b01100000110, 11'b01100000110,
     11'b01111111110, 11'b01100000110, 11'b01100000110, 11'b01100000110, 11'b00000000000},
    {11'b11000000011, 11'b11100000111, 11'b11110001111, 11'b11011011011, 11'b11001110011,
     11'b11000100011, 11'b11000000011, 11'b11000000011, 11'b11000000011, 11'b00000000000},
    {11'b11111111110, 11'b11000000000, 11'b11000000000, 11'b11000000000, 11'b11111111000,
     11'b11000000000, 11'b11000000000, 11'b11000000000, 11'b11111111110, 11'b00000000000},
    {11'b00111111100, 11'b01100000110, 11'b11000000011, 11'b11000000011, 11'b11000000011,
     11'b11000000011, 11'b11000000011, 11'b01100000110, 11'b00111111100, 11'b00000000000},
    {11'b11000000011, 11'b11000000011, 11'b01100000110, 11'b01100000110, 11'b00110001100,
     11'b00110001100, 11'b00011011000, 11'b00011011000, 11'b00001110000, 11'b00000100000},
    {11'b11111111000, 11'b11000000110, 11'b11000000110, 11'b11000000110, 11'b11111111000,
     11'b11001100000, 11'b11000110000, 11'b11000011000, 11'b11000001100, 11'b11000000110}
  };
  typedef enum logic [1:0] {OFF, ON, HIDE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0] shadow [N_CHARS];
  logic [2:0] active [N_CHARS];
  logic vs_prev, frame, show, draw;
  logic [15:0] h, v, dx, dy;
  logic hit, hit1, hs1, vs1, bl1, pix;
  logic [IW-1:0] idx, idx1;
  logic [3:0] row1, col1;
  logic [9:0] hc1, vc1;
  logic [23:0] rgb1, fill;
  logic [6:0] base;
  logic [109:0] glyph;
  logic [10:0] frow;
  function automatic logic [15:0] cell_x(input int i);
    return 16'(X0 + (i % CHARS_PER_ROW) * CHAR_PITCH);
  endfunction
  function automatic logic [15:0] cell_y(input int i);
    return 16'(Y0 + (i / CHARS_PER_ROW) * ROW_PITCH);
  endfunction
  assign frame = vsync_in & ~vs_prev;
  assign h = {6'd0, hcount_in};
  assign v = {6'd0, vcount_in};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vs_prev <= 1'b0;
      shadow <= '{default: '0};
      active <= '{default: '0};
    end else begin
      vs_prev <= vsync_in;
      if (wr_en && {1'b0, wr_addr} < 5'(N_CHARS)) shadow[wr_addr[IW-1:0]] <= wr_code;
      if (frame) active <= shadow;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= OFF;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (frame)
      case (state)
        OFF: if (enable) begin state_nx = ON; cnt_nx = '0; end
        ON:
          if (!enable) state_nx = OFF;
          else if (BLINK_FRAMES > 0 && cnt == CW'(BLINK_FRAMES - 1)) begin state_nx = HIDE; cnt_nx = '0; end
          else cnt_nx = cnt + 1'b1;
        HIDE:
          if (!enable) state_nx = OFF;
          else if (cnt == CW'(BLINK_FRAMES - 1)) begin state_nx = ON; cnt_nx = '0; end
          else cnt_nx = cnt + 1'b1;
        default: state_nx = OFF;
      endcase
  end
  always_comb begin
    show = state != OFF;
    draw = state == ON;
  end
  // Boxes never overlap, so at most one cell matches.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    dx = '0;
    dy = '0;
    for (int i = 0; i < N_CHARS; i++)
      if (h >= cell_x(i) && h < cell_x(i) + 16'(11 * SCALE) &&
          v >= cell_y(i) && v < cell_y(i) + 16'(10 * SCALE)) begin
        hit = 1'b1;
        idx = IW'(i);
        dx = h - cell_x(i);
        dy = v - cell_y(i);
      end
  end
  assign glyph = FONT[active[idx1]];
  assign base = 7'(4'd9 - row1) * 7'd11;
  assign frow = glyph[base +: 11];
  assign pix = hit1 & frow[4'd10 - col1];
`ifdef TEXT_OVERLAY_TRANSPARENT_EN
  assign fill = rgb1;
`else
  assign fill = BG;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {hit1, idx1, row1, col1, hc1, vc1, hs1, vs1, bl1, rgb1} <= '0;
      {hcount_out, vcount_out, hsync_out, vsync_out, blnk_out, rgb_out} <= '0;
    end else begin
      hit1 <= hit;
      idx1 <= idx;
      row1 <= 4'(dy / 16'(SCALE));
      col1 <= 4'(dx / 16'(SCALE));
      {hc1, vc1, hs1, vs1, bl1, rgb1} <= {hcount_in, vcount_in, hsync_in, vsync_in, blnk_in, rgb_in};
      {hcount_out, vcount_out, hsync_out, vsync_out, blnk_out} <= {hc1, vc1, hs1, vs1, bl1};
      rgb_out <= !show ? rgb1 : bl1 ? 24'd0 : (draw && pix) ? FG : fill;
    end
endmodule

// File: tb/tb_text_overlay.sv
// tb_text_overlay: directed scoreboard bench for text_overlay with BLINK_FRAMES=2.
module tb_text_overlay;
  logic clk = 0, rst = 1, enable = 0, wr_en = 0;
  logic [3:0] wr_addr = 0;
  logic [2:0] wr_code = 0;
  logic [9:0] hcount_in = 0, vcount_in = 0, hcount_out, vcount_out;
  logic hsync_in = 0, vsync_in = 0, blnk_in = 0, hsync_out, vsync_out, blnk_out;
  logic [23:0] rgb_in = 0, rgb_out;
  logic chk = 0, v1 = 0, v2 = 0;
  int total = 0, bad = 0;
  logic [22:0] tq [$];
  logic [23:0] rq [$];
  string nq [$];
  localparam int W = 24'hFFFFFF;

  text_overlay #(.BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr), .wr_code(wr_code),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .blnk_in(blnk_in), .rgb_in(rgb_in), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .blnk_out(blnk_out), .rgb_out(rgb_out));

  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  always @(posedge clk) begin
    v1 <= chk;
    v2 <= v1;
  end

  always @(negedge clk)
    if (v2) begin
      if (rq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard: output presented with no expectation queued");
      end else begin
        logic [22:0] et;
        logic [23:0] er;
        string nm;
        et = tq.pop_front();
        er = rq.pop_front();
        nm = nq.pop_front();
        check({nm, "_rgb"}, 32'(rgb_out), 32'(er));
        check({nm, "_tim"}, 32'({hcount_out, vcount_out, hsync_out, vsync_out, blnk_out}), 32'(et));
      end
    end

  task automatic px(input string nm, input int x, input int y, input logic hs, input logic bl,
                    input int rgb, input int exp);
    @(negedge clk);
    {hcount_in, vcount_in, hsync_in, vsync_in, blnk_in, rgb_in} = {10'(x), 10'(y), hs, 1'b0, bl, 24'(rgb)};
    wr_en = 0;
    chk = 1;
    tq.push_back({10'(x), 10'(y), hs, 1'b0, bl});
    rq.push_back(24'(exp));
    nq.push_back(nm);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      {chk, wr_en, vsync_in} = 3'b000;
    end
  endtask

  task automatic wr(input int a, input int c);
    @(negedge clk);
    {chk, vsync_in} = 2'b00;
    wr_en = 1;
    wr_addr = 4'(a);
    wr_code = 3'(c);
  endtask

  task automatic frame(input logic w, input int a, input int c);
    idle(2);
    @(negedge clk);
    chk = 0;
    vsync_in = 1;
    wr_en = w;
    wr_addr = 4'(a);
    wr_code = 3'(c);
    idle(1);
  endtask

  initial begin
    hcount_in = 10'd5;
    rgb_in = 24'h123456;
    repeat (3) @(negedge clk);
    check("rst_rgb", 32'(rgb_out), 0);
    check("rst_tim", 32'({hcount_out, vcount_out, hsync_out, vsync_out, blnk_out}), 0);
    rst = 0;
    for (int i = 0; i < 6; i++)
      px("pass", 100 + i, 20, i[0], i == 4, 24'h123456 + i, 24'h123456 + i);
    enable = 1;
    wr(0, 1);
    wr(5, 4);
    px("en_mid_frame", 147, 135, 0, 0, 24'hABCDEF, 24'hABCDEF);
    frame(0, 0, 0);
    px("g_top", 147, 135, 0, 0, 24'h555555, W);
    px("g_left", 120, 135, 0, 0, 24'h555555, 0);
    px("left_out", 119, 135, 0, 0, 24'h555555, 0);
    px("g_r2", 129, 153, 0, 0, 24'h555555, W);
    px("g_r4", 201, 171, 0, 0, 24'h555555, W);
    px("gap", 219, 135, 0, 0, 24'h555555, 0);
    px("g_blnk", 147, 135, 0, 1, 24'h555555, 0);
    px("e_c5", 265, 255, 0, 0, 24'h555555, W);
    px("e_c10", 318, 255, 0, 0, 24'h555555, 0);
    wr(5, 6);
    wr(12, 6);
    px("e_hold", 265, 255, 0, 0, 24'h555555, W);
    px("e_hold10", 318, 255, 0, 0, 24'h555555, 0);
    frame(1, 0, 7);
    px("v_c5", 265, 255, 0, 0, 24'h555555, 0);
    px("v_edge", 318, 255, 0, 0, 24'h555555, W);
    px("v_bottom", 265, 344, 0, 0, 24'h555555, W);
    px("v_right_out", 319, 255, 0, 0, 24'h555555, 0);
    px("v_below", 265, 345, 0, 0, 24'h555555, 0);
    px("addr12_ignored", 120, 255, 0, 0, 24'h555555, 0);
    px("coincident_wr", 120, 135, 0, 0, 24'h555555, 0);
    frame(0, 0, 0);
    px("hide1", 120, 135, 0, 0, 24'h555555, 0);
    px("hide1_v", 318, 255, 0, 0, 24'h555555, 0);
    frame(0, 0, 0);
    px("hide2", 120, 135, 0, 0, 24'h555555, 0);
    frame(0, 0, 0);
    px("r_on", 120, 135, 0, 0, 24'h555555, W);
    px("r_c3", 147, 135, 0, 0, 24'h555555, W);
    enable = 0;
    px("drop_mid", 120, 135, 0, 0, 24'h555555, W);
    frame(0, 0, 0);
    px("off_pass", 120, 135, 0, 0, 24'h555555, 24'h555555);
    enable = 1;
    frame(0, 0, 0);
    px("on_again", 120, 135, 0, 0, 24'h555555, W);
    idle(3);
    @(posedge clk);
    #2 rst = 1;
    #1;
    check("arst_rgb", 32'(rgb_out), 0);
    check("arst_tim", 32'({hcount_out, vcount_out, hsync_out, vsync_out, blnk_out}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    px("rst_pass", 120, 135, 0, 0, 24'h13579B, 24'h13579B);
    frame(0, 0, 0);
    px("blank_buf", 147, 135, 0, 0, 24'h2468AC, 0);
    wr(0, 1);
    frame(0, 0, 0);
    px("rewrite", 147, 135, 0, 0, 24'h2468AC, W);
    idle(4);
    if (rq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations never met", rq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/text_overlay.md
Name: text_overlay

Overview:
- Parametrised bitmap-text overlay for the VGA pixel chain. Replaces the fixed 8-letter "GAME OVER" screen.
- Draws up to N_CHARS glyphs from the team 11x10 font, each scaled by SCALE, on a grid of CHARS_PER_ROW columns. Any register-chain pixel outside the text can be passed through or blanked.
- String contents are loaded at run time through a write port. Writes go to a shadow buffer that commits at frame boundaries, so the display never tears.
- Optional blinking. Sits in the timing/RGB register chain like the other overlay stages.

Parameters:
N_CHARS, 8, number of character cells (1..16)
CHARS_PER_ROW, 4, cells per text row
SCALE, 9, integer pixel magnification of 11x10 glyph (1..15)
X0, 120, hcount of top-left pixel of cell 0
Y0, 135, vcount of top-left pixel of cell 0
CHAR_PITCH, 100, horizontal distance between cell origins (>= 11*SCALE)
ROW_PITCH, 120, vertical distance between row origins (>= 10*SCALE)
BLINK_FRAMES, 0, frames per blink half-period; 0 = no blink
FG, 24'hFFFFFF, glyph pixel colour
BG, 24'h000000, non-glyph colour while overlay shown

Ports:
clk  in  1  pixel clock
rst  in  1  asynchronous, active-high reset
enable  in  1  request overlay display (e.g. gameover)
wr_en  in  1  character write strobe
wr_addr  in  4  cell index
wr_code  in  3  glyph code: 0 blank, 1 G, 2 A, 3 M, 4 E, 5 O, 6 V, 7 R
hcount_in  in  10  pixel column
vcount_in  in  10  pixel row
hsync_in, vsync_in, blnk_in  in  1 each  timing
rgb_in  in  24  upstream pixel
hcount_out, vcount_out  out  10 each  delayed timing
hsync_out, vsync_out, blnk_out  out  1 each  delayed timing
rgb_out  out  24  composited pixel

Behaviour:
- Reset: all outputs 0; shadow and active buffers all code 0; state OFF; frame counter 0; vsync edge register 0.
- Latency: exactly 2 clk for every output. Timing signals are delayed through 2 register stages, aligned with rgb_out.
  - Stage 1 registers: cell hit, cell index, glyph row ((vcount-celly)/SCALE), glyph column ((hcount-cellx)/SCALE).
  - Stage 2 registers: glyph bit lookup and colour mux.
- Geometry: cell i has r=i/CHARS_PER_ROW and c=i%CHARS_PER_ROW.
  - Box spans x in [X0+c*CHAR_PITCH, +11*SCALE-1] and y in [Y0+r*ROW_PITCH, +10*SCALE-1], inclusive.
  - Compares are unsigned and at least 11 bits wide, so there is no wrap; pixels left of or above a box never hit.
  - Font row 0 is the top; bit 10 is the leftmost column.
- Write port: wr_en with wr_addr < N_CHARS updates the shadow entry the next cycle. wr_addr >= N_CHARS is ignored.
- Frame boundary = rising edge of vsync_in (vsync_in=1, previous=0). At a frame boundary:
  - shadow copies to active;
  - enable is sampled;
  - the blink counter advances.
  - A write in the same cycle as the boundary lands in shadow and is NOT part of that commit.
- FSM, transitions only at frame boundary:
  - OFF: pass rgb_in. enable=1 -> ON; frame counter cleared.
  - ON: overlay drawn. enable=0 -> OFF. Otherwise, if BLINK_FRAMES>0 and counter==BLINK_FRAMES-1 -> HIDE, counter cleared; else counter+1.
  - HIDE: output is BG everywhere, text suppressed. enable=0 -> OFF. Otherwise, if counter==BLINK_FRAMES-1 -> ON, counter cleared; else counter+1.
- Pixel mux (stage 2):
  - state OFF -> rgb_in (delayed);
  - blnk delayed = 1 -> 0;
  - ON and glyph bit = 1 -> FG;
  - otherwise -> BG.
  - Code 0 is all zeros.
- enable toggling mid-frame has no effect until the next frame boundary.
- rst mid-frame returns to OFF immediately; the buffers are cleared.

Optional Feature:
- TEXT_OVERLAY_TRANSPARENT_EN defined: in ON and HIDE, non-glyph pixels output delayed rgb_in instead of BG, giving text over the game scene.
- Undefined: non-glyph pixels are BG, as in Behaviour.

Test Plan:
1. Reset, enable=0, rgb_in=24'h123456 ramp -> rgb_out equals rgb_in delayed 2 clk; hcount_out/vsync_out also delayed 2.
2. Write cell0=1(G) mid-frame, enable=1, wait one boundary -> pixel (147,135) = FFFFFF and (120,135) = 000000 two clk after presentation; (119,135) = BG.
3. Write cell5=6(V) during frame N, after enable has already taken effect -> frame N still shows the old cell5; frame N+1 shows V at box x 220..318, y 255..344.
4. wr_addr=12 with N_CHARS=8 -> no visible change; a write coincident with the vsync rising edge appears one frame later.
5. BLINK_FRAMES=2, enable held -> sequence ON,ON,HIDE,HIDE,ON per frame; drop enable -> OFF at the next boundary, pass-through.
6. Assert rst mid-line while ON -> outputs 0 asynchronously; after release, pass-through with blank buffers until new writes plus a boundary.
